// File: rtl/shift_seq_pkg.sv
// Shared widths, op encodings and FSM state codes for the shift sequencer.
package shift_seq_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned AMT_W  = 6;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CTR_W  = 5;

    localparam logic [OP_W-1:0] OP_SLL  = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL  = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA  = 3'd2;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd3;
    localparam logic [OP_W-1:0] OP_DSLL = 3'd4;
    localparam logic [OP_W-1:0] OP_DSRL = 3'd5;
    localparam logic [OP_W-1:0] OP_DSRA = 3'd6;
    localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StP1   = 2'd1;
    localparam state_t StP2   = 2'd2;
    localparam state_t StDone = 2'd3;

    function automatic logic is_dword(input logic [OP_W-1:0] op);
        return (op == OP_DSLL) || (op == OP_DSRL) || (op == OP_DSRA);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request, response and funnel-shifter signals of the shift sequencer.
interface shift_sequencer_if;
    import shift_seq_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [OP_W-1:0]         req_op;
    logic [AMT_W-1:0]        req_amt;
    logic [WORD_W-1:0]       req_lo;
    logic [WORD_W-1:0]       req_hi;

    logic [WORD_W-2:0]       sh_a;
    logic [WORD_W-1:0]       sh_b;
    logic [CTR_W-1:0]        sh_ctr;
    logic [WORD_W-1:0]       sh_r;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [WORD_W-1:0]       resp_lo;
    logic [WORD_W-1:0]       resp_hi;
    logic                    resp_err;

    // Parent side: issues requests, hosts the shifter, consumes responses.
    modport master (
        output req_valid, req_op, req_amt, req_lo, req_hi, sh_r, resp_ready,
        input  req_ready, sh_a, sh_b, sh_ctr, resp_valid, resp_lo, resp_hi, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_amt, req_lo, req_hi, sh_r, resp_ready,
        output req_ready, sh_a, sh_b, sh_ctr, resp_valid, resp_lo, resp_hi, resp_err
    );

endinterface

// File: rtl/shift_seq_operand_mux.sv
// Maps (op, amount, operands, pass) onto funnel shifter A/B/Ctr inputs.
module shift_seq_operand_mux
    import shift_seq_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [AMT_W-1:0]  amt_i,
    input  logic [WORD_W-1:0] lo_i,
    input  logic [WORD_W-1:0] hi_i,
    input  logic              pass_i,
    output logic [WORD_W-2:0] sh_a_o,
    output logic [WORD_W-1:0] sh_b_o,
    output logic [CTR_W-1:0]  sh_ctr_o
);

    logic [CTR_W-1:0]  n;
    logic [CTR_W-1:0]  n_left;
    logic              big;
    logic              fill_b;
    logic [WORD_W-2:0] fill_a;

    assign n      = amt_i[CTR_W-1:0];
    assign n_left = 5'd0 - n;  // 32-n, valid for n>0
    assign big    = amt_i[AMT_W-1];
    assign fill_b = (op_i == OP_DSRA) && hi_i[WORD_W-1];
    assign fill_a = {(WORD_W-1){fill_b}};

    always_comb begin
        sh_a_o   = '0;
        sh_b_o   = '0;
        sh_ctr_o = '0;
        case (op_i)
            OP_SLL: begin
                if (n == '0) begin
                    sh_b_o = lo_i;
                end else begin
                    sh_a_o   = lo_i[WORD_W-2:0];
                    sh_ctr_o = n_left;
                end
            end
            OP_SRL: begin
                sh_b_o   = lo_i;
                sh_ctr_o = n;
            end
            OP_SRA: begin
                sh_a_o   = {(WORD_W-1){lo_i[WORD_W-1]}};
                sh_b_o   = lo_i;
                sh_ctr_o = n;
            end
            OP_ROR: begin
                sh_a_o   = lo_i[WORD_W-2:0];
                sh_b_o   = lo_i;
                sh_ctr_o = n;
            end
            OP_DSRL, OP_DSRA: begin
                if (!big) begin
                    sh_a_o   = pass_i ? fill_a : hi_i[WORD_W-2:0];
                    sh_b_o   = pass_i ? hi_i : lo_i;
                    sh_ctr_o = n;
                end else if (!pass_i) begin
                    sh_a_o   = fill_a;
                    sh_b_o   = hi_i;
                    sh_ctr_o = n;
                end else begin
                    sh_a_o = fill_a;
                    sh_b_o = {WORD_W{fill_b}};
                end
            end
            OP_DSLL: begin
                if (!big) begin
                    if (n == '0) begin
                        sh_b_o = pass_i ? hi_i : lo_i;
                    end else begin
                        sh_a_o   = pass_i ? hi_i[WORD_W-2:0] : lo_i[WORD_W-2:0];
                        sh_b_o   = pass_i ? lo_i : '0;
                        sh_ctr_o = n_left;
                    end
                end else if (pass_i) begin
                    // High word is lo shifted left by n-32; low word stays zero.
                    if (n == '0) begin
                        sh_b_o = lo_i;
                    end else begin
                        sh_a_o   = lo_i[WORD_W-2:0];
                        sh_ctr_o = n_left;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences SLL/SRL/SRA/ROR (one pass) and DSLL/DSRL/DSRA (two passes) onto an external
// funnel shifter. Define SHIFT_SEQ_PERF_EN to add the perf_ops completed-response counter.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef SHIFT_SEQ_PERF_EN
    output logic [31:0]       perf_ops,
`endif
    shift_sequencer_if.slave  bus
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [WORD_W-1:0] resp_lo_q, resp_lo_d;
    logic [WORD_W-1:0] resp_hi_q, resp_hi_d;

    logic [WORD_W-2:0] mux_a;
    logic [WORD_W-1:0] mux_b;
    logic [CTR_W-1:0]  mux_ctr;
    logic              busy;

    shift_seq_operand_mux u_operand_mux (
        .op_i     (op_q),
        .amt_i    (amt_q),
        .lo_i     (lo_q),
        .hi_i     (hi_q),
        .pass_i   (state_q == StP2),
        .sh_a_o   (mux_a),
        .sh_b_o   (mux_b),
        .sh_ctr_o (mux_ctr)
    );

    assign busy           = (state_q == StP1) || (state_q == StP2);
    assign bus.sh_a       = busy ? mux_a : '0;
    assign bus.sh_b       = busy ? mux_b : '0;
    assign bus.sh_ctr     = busy ? mux_ctr : '0;
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_lo    = resp_lo_q;
    assign bus.resp_hi    = resp_hi_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        amt_d        = amt_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_lo_d    = resp_lo_q;
        resp_hi_d    = resp_hi_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    amt_d   = bus.req_amt;
                    lo_d    = bus.req_lo;
                    hi_d    = bus.req_hi;
                    state_d = StP1;
                end
            end
            StP1: begin
                resp_err_d = (op_q == OP_ILL);
                resp_lo_d  = (op_q == OP_ILL) ? '0 : bus.sh_r;
                resp_hi_d  = '0;
                if (is_dword(op_q)) begin
                    state_d = StP2;
                end else begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                end
            end
            StP2: begin
                resp_hi_d    = bus.sh_r;
                resp_valid_d = 1'b1;
                state_d      = StDone;
            end
            StDone: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            amt_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_lo_q    <= '0;
            resp_hi_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            amt_q        <= amt_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_lo_q    <= resp_lo_d;
            resp_hi_q    <= resp_hi_d;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d   = perf_q + 32'(resp_valid_q && bus.resp_ready);
    assign perf_ops = perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural funnel shifter on the sh_* bus.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_sequencer_if bus_if ();

    logic [62:0] funnel;
    assign funnel     = {bus_if.sh_a, bus_if.sh_b};
    assign bus_if.sh_r = 32'(funnel >> bus_if.sh_ctr);

`ifdef SHIFT_SEQ_PERF_EN
    logic [31:0] perf_ops;
    int          n_done = 0;
`endif

    shift_sequencer dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SHIFT_SEQ_PERF_EN
        .perf_ops (perf_ops),
`endif
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] amt,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_err, input int lat, input int hold);
        chk({tag, " req_ready idle"}, 64'(bus_if.req_ready), 64'd1);
        bus_if.req_op     = op;
        bus_if.req_amt    = amt;
        bus_if.req_lo     = lo;
        bus_if.req_hi     = hi;
        bus_if.req_valid  = 1'b1;
        bus_if.resp_ready = 1'b0;
        step();
        bus_if.req_valid = 1'b0;
        chk({tag, " req_ready busy"}, 64'(bus_if.req_ready), 64'd0);
        for (int i = 0; i < lat; i++) begin
            chk({tag, " early valid"}, 64'(bus_if.resp_valid), 64'd0);
            step();
        end
        chk({tag, " resp_valid"}, 64'(bus_if.resp_valid), 64'd1);
        chk({tag, " resp_lo"}, 64'(bus_if.resp_lo), 64'(exp_lo));
        chk({tag, " resp_hi"}, 64'(bus_if.resp_hi), 64'(exp_hi));
        chk({tag, " resp_err"}, 64'(bus_if.resp_err), 64'(exp_err));
        chk({tag, " sh idle a"}, 64'(bus_if.sh_a), 64'd0);
        chk({tag, " sh idle b/ctr"}, {27'd0, bus_if.sh_ctr, bus_if.sh_b}, 64'd0);
        // Hold backpressure while a competing request waits.
        for (int i = 0; i < hold; i++) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_op    = OP_SLL;
            bus_if.req_amt   = 6'd1;
            bus_if.req_lo    = 32'hFFFF_FFFF;
            step();
            chk({tag, " hold valid"}, 64'(bus_if.resp_valid), 64'd1);
            chk({tag, " hold lo"}, 64'(bus_if.resp_lo), 64'(exp_lo));
            chk({tag, " hold hi"}, 64'(bus_if.resp_hi), 64'(exp_hi));
            chk({tag, " hold req_ready"}, 64'(bus_if.req_ready), 64'd0);
        end
        bus_if.req_valid  = 1'b0;
        bus_if.resp_ready = 1'b1;
        step();
        bus_if.resp_ready = 1'b0;
`ifdef SHIFT_SEQ_PERF_EN
        n_done++;
`endif
        chk({tag, " valid cleared"}, 64'(bus_if.resp_valid), 64'd0);
        chk({tag, " ready again"}, 64'(bus_if.req_ready), 64'd1);
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_op     = '0;
        bus_if.req_amt    = '0;
        bus_if.req_lo     = '0;
        bus_if.req_hi     = '0;
        bus_if.resp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst req_ready", 64'(bus_if.req_ready), 64'd1);
        chk("rst resp_valid", 64'(bus_if.resp_valid), 64'd0);
        chk("rst resp_err", 64'(bus_if.resp_err), 64'd0);
        chk("rst resp_words", {bus_if.resp_hi, bus_if.resp_lo}, 64'd0);
        chk("rst sh_a", 64'(bus_if.sh_a), 64'd0);
        chk("rst sh_b/ctr", {27'd0, bus_if.sh_ctr, bus_if.sh_b}, 64'd0);

        // Stray resp_ready while idle must not disturb anything.
        bus_if.resp_ready = 1'b1;
        step();
        bus_if.resp_ready = 1'b0;
        chk("stray ready", 64'(bus_if.resp_valid), 64'd0);

        run_op("sll31", OP_SLL, 6'd31, 32'h0000_0001, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1, 0);
        run_op("sll0", OP_SLL, 6'd0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 0);
        run_op("sra31", OP_SRA, 6'd31, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0);
        run_op("ror4", OP_ROR, 6'd4, 32'h0000_00F1, 32'h0, 32'h1000_000F, 32'h0, 1'b0, 1, 0);
        run_op("ror0", OP_ROR, 6'd0, 32'h0000_00F1, 32'h0, 32'h0000_00F1, 32'h0, 1'b0, 1, 0);
        run_op("srl amt5 ign", OP_SRL, 6'h24, 32'h8000_0000, 32'h5555_5555, 32'h0800_0000,
               32'h0, 1'b0, 1, 0);
        run_op("dsra36", OP_DSRA, 6'd36, 32'h0, 32'h8000_0000, 32'hF800_0000, 32'hFFFF_FFFF,
               1'b0, 2, 0);
        run_op("dsra4", OP_DSRA, 6'd4, 32'h0000_0010, 32'h8000_0000, 32'h0000_0001,
               32'hF800_0000, 1'b0, 2, 0);
        run_op("dsll33", OP_DSLL, 6'd33, 32'h0000_0001, 32'h0, 32'h0, 32'h0000_0002, 1'b0, 2, 0);
        run_op("dsll4", OP_DSLL, 6'd4, 32'h9ABC_DEF0, 32'h1234_5678, 32'hABCD_EF00,
               32'h2345_6789, 1'b0, 2, 0);
        run_op("dsll0", OP_DSLL, 6'd0, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0,
               32'h1234_5678, 1'b0, 2, 0);
        run_op("dsrl8", OP_DSRL, 6'd8, 32'h9ABC_DEF0, 32'h1234_5678, 32'h789A_BCDE,
               32'h0012_3456, 1'b0, 2, 0);
        run_op("dsrl32", OP_DSRL, 6'd32, 32'h9ABC_DEF0, 32'h1234_5678, 32'h1234_5678, 32'h0,
               1'b0, 2, 0);
        run_op("backpressure", OP_SRL, 6'd4, 32'h0000_00F0, 32'h0, 32'h0000_000F, 32'h0,
               1'b0, 1, 5);
        run_op("illegal", OP_ILL, 6'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1, 0);
        run_op("err clears", OP_SRL, 6'd1, 32'h0000_0002, 32'h0, 32'h0000_0001, 32'h0,
               1'b0, 1, 0);

        // Abort a DSRL during its second pass.
        bus_if.req_op    = OP_DSRL;
        bus_if.req_amt   = 6'd8;
        bus_if.req_lo    = 32'h9ABC_DEF0;
        bus_if.req_hi    = 32'h1234_5678;
        bus_if.req_valid = 1'b1;
        step();
        bus_if.req_valid = 1'b0;
        chk("abort p1 ctr", 64'(bus_if.sh_ctr), 64'd8);
        step();
        chk("abort p2 sh_b", 64'(bus_if.sh_b), 64'h1234_5678);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort resp_valid", 64'(bus_if.resp_valid), 64'd0);
        chk("abort req_ready", 64'(bus_if.req_ready), 64'd1);
        chk("abort resp_words", {bus_if.resp_hi, bus_if.resp_lo}, 64'd0);
        chk("abort sh_b", 64'(bus_if.sh_b), 64'd0);
        step();
        chk("abort stays idle", 64'(bus_if.resp_valid), 64'd0);

`ifdef SHIFT_SEQ_PERF_EN
        n_done = 0;
        chk("perf after rst", 64'(perf_ops), 64'd0);
`endif
        run_op("post sll", OP_SLL, 6'd4, 32'h0000_000F, 32'h0, 32'h0000_00F0, 32'h0, 1'b0, 1, 0);
        run_op("post dsrl", OP_DSRL, 6'd63, 32'h0, 32'h8000_0000, 32'h0000_0001, 32'h0,
               1'b0, 2, 0);
        run_op("post sra", OP_SRA, 6'd1, 32'h7FFF_FFFE, 32'h0, 32'h3FFF_FFFF, 32'h0, 1'b0, 1, 0);
`ifdef SHIFT_SEQ_PERF_EN
        chk("perf count", 64'(perf_ops), 64'(n_done));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
